// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the RV32I MEM stage.
// Accepts one load/store from the pipeline, checks alignment, then runs a
// request/grant/response transaction on the data bus. The pipeline is stalled
// for the duration. Store data is replicated across byte lanes so the bus
// strobes alone select the written bytes. Load data is returned raw (word
// aligned) for the load/store unit to shift and extend.
module dmem_access_ctrl #(
    parameter int data_width     = 32,
    parameter int timeout_cycles = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic                    req_store,
    input  logic [data_width-1:0]   req_addr,
    input  logic [2:0]              req_funct3,
    input  logic [data_width-1:0]   req_wdata,
    input  logic [data_width/8-1:0] lsu_we,
    output logic [2:0]              lsu_funct3,
    output logic [1:0]              lsu_addr_lsb,
    output logic                    lsu_rd_or_wr_bar,
    output logic [data_width-1:0]   lsu_mem_data,
    output logic                    stall,
    output logic                    resp_valid,
    output logic                    misalign,
    output logic                    bus_fault,
    output logic                    bus_req,
    output logic                    bus_wr,
    output logic [data_width-1:0]   bus_addr,
    output logic [data_width-1:0]   bus_wdata,
    output logic [data_width/8-1:0] bus_wstrb,
    input  logic                    bus_gnt,
    input  logic                    bus_rvalid,
    input  logic [data_width-1:0]   bus_rdata,
    input  logic                    bus_err
);

    localparam int lanes = data_width / 8;
    localparam int cnt_w = $clog2(timeout_cycles + 1);
    localparam logic [cnt_w-1:0] tmo_last = cnt_w'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [2:0]              lsu_funct3_reg;
    logic [1:0]              lsu_addr_lsb_reg;
    logic                    lsu_rd_or_wr_bar_reg;
    logic [data_width-1:0]   lsu_mem_data_reg;
    logic                    resp_valid_reg;
    logic                    misalign_reg;
    logic                    bus_fault_reg;
    logic                    bus_req_reg;
    logic                    bus_wr_reg;
    logic [data_width-1:0]   bus_addr_reg;
    logic [data_width-1:0]   bus_wdata_reg;
    logic [cnt_w-1:0]        tmo_cnt_reg;

    logic                    req_illegal;
    logic                    rsp_take;
    logic                    tmo_hit;
    logic [data_width-1:0]   wdata_rep;

    // Classify the incoming request: reserved encodings, unsigned stores and
    // naturally misaligned halfwords/words are all rejected before the bus.
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
            3'b001, 3'b101:         req_illegal = req_addr[0];
            3'b010:                 req_illegal = (req_addr[1:0] != 2'b00);
            default:                req_illegal = 1'b0;
        endcase
        if (req_store && req_funct3[2]) begin
            req_illegal = 1'b1;
        end
    end

    // Byte lane replication: byte stores copy byte 0 to every lane, halfword
    // stores copy the low halfword to both halves, word stores pass through.
    generate
        for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
            assign wdata_rep[gi*8 +: 8] =
                (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
                (req_funct3[1:0] == 2'b01) ? req_wdata[(gi % 2)*8 +: 8] :
                                             req_wdata[gi*8 +: 8];
        end
    endgenerate

    // A response counts in REQ only together with the grant (grant then
    // response in the same cycle); in WAIT any response completes.
    assign rsp_take = bus_rvalid &&
                      (((state_reg == REQ) && bus_gnt) || (state_reg == WAIT));
    assign tmo_hit  = (tmo_cnt_reg == tmo_last);

    // Transaction sequencer with registered bus controls and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= IDLE;
            lsu_funct3_reg       <= 3'b000;
            lsu_addr_lsb_reg     <= 2'b00;
            lsu_rd_or_wr_bar_reg <= 1'b1;
            lsu_mem_data_reg     <= '0;
            resp_valid_reg       <= 1'b0;
            misalign_reg         <= 1'b0;
            bus_fault_reg        <= 1'b0;
            bus_req_reg          <= 1'b0;
            bus_wr_reg           <= 1'b0;
            bus_addr_reg         <= '0;
            bus_wdata_reg        <= '0;
            tmo_cnt_reg          <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            bus_fault_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        if (req_illegal) begin
                            misalign_reg <= 1'b1;
                        end else begin
                            lsu_funct3_reg       <= req_funct3;
                            lsu_addr_lsb_reg     <= req_addr[1:0];
                            lsu_rd_or_wr_bar_reg <= ~req_store;
                            bus_wr_reg           <= req_store;
                            bus_addr_reg         <= {req_addr[data_width-1:2], 2'b00};
                            bus_wdata_reg        <= wdata_rep;
                            bus_req_reg          <= 1'b1;
                            tmo_cnt_reg          <= '0;
                            state_reg            <= REQ;
                        end
                    end
                end
                REQ, WAIT: begin
                    tmo_cnt_reg <= tmo_cnt_reg + cnt_w'(1);
                    if (rsp_take) begin
                        bus_req_reg <= 1'b0;
                        if (bus_err) begin
                            bus_fault_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end else begin
                            if (!bus_wr_reg) begin
                                lsu_mem_data_reg <= bus_rdata;
                            end
                            resp_valid_reg <= 1'b1;
                            state_reg      <= DONE;
                        end
                    end else if (tmo_hit) begin
                        bus_req_reg   <= 1'b0;
                        bus_fault_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else if ((state_reg == REQ) && bus_gnt) begin
                        bus_req_reg <= 1'b0;
                        state_reg   <= WAIT;
                    end
                end
                DONE: begin
                    // Request lines are ignored here; the next one is taken in IDLE.
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Stall covers the accepting cycle and the whole bus transaction; it is
    // forced low while reset is asserted.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE:      stall = req_valid && !req_illegal;
                REQ, WAIT: stall = 1'b1;
                default:   stall = 1'b0;
            endcase
        end
    end

    // Strobes come from the load/store unit and are only presented for a
    // write while the request is outstanding.
    assign bus_wstrb = (bus_req_reg && bus_wr_reg) ? lsu_we : '0;

    assign lsu_funct3       = lsu_funct3_reg;
    assign lsu_addr_lsb     = lsu_addr_lsb_reg;
    assign lsu_rd_or_wr_bar = lsu_rd_or_wr_bar_reg;
    assign lsu_mem_data     = lsu_mem_data_reg;
    assign resp_valid       = resp_valid_reg;
    assign misalign         = misalign_reg;
    assign bus_fault        = bus_fault_reg;
    assign bus_req          = bus_req_reg;
    assign bus_wr           = bus_wr_reg;
    assign bus_addr         = bus_addr_reg;
    assign bus_wdata        = bus_wdata_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios followed by
// randomized loads/stores, each checked against a simple transaction model.
module tb_dmem_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  lsu_we = '0;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_addr_lsb;
    logic        lsu_rd_or_wr_bar;
    logic [31:0] lsu_mem_data;
    logic        stall, resp_valid, misalign, bus_fault, bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.data_width(32), .timeout_cycles(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_wdata(req_wdata), .lsu_we(lsu_we),
        .lsu_funct3(lsu_funct3), .lsu_addr_lsb(lsu_addr_lsb),
        .lsu_rd_or_wr_bar(lsu_rd_or_wr_bar), .lsu_mem_data(lsu_mem_data),
        .stall(stall), .resp_valid(resp_valid), .misalign(misalign),
        .bus_fault(bus_fault), .bus_req(bus_req), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Architectural view of what the LSU-facing outputs should hold.
    logic [31:0] mdl_mem;
    logic [2:0]  mdl_f3;
    logic [1:0]  mdl_lsb;
    logic        mdl_dir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Access size in bytes for a funct3, 0 when the access does not exist.
    function automatic int acc_size(input logic [2:0] f3, input logic st);
        int sz;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        if (st && f3 > 3'd2) sz = 0;
        return sz;
    endfunction

    function automatic logic is_legal(input logic [2:0] f3, input logic st, input logic [31:0] a);
        int sz;
        int lo;
        sz = acc_size(f3, st);
        lo = int'(a[1:0]);
        return (sz != 0) && ((lo % sz) == 0);
    endfunction

    // Every byte lane carries the store byte at the same offset modulo size.
    function automatic logic [31:0] replicate(input logic [31:0] wd, input int sz);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [31:0] a, input int sz);
        logic [3:0] be;
        int lo;
        lo = int'(a[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + sz);
        return be;
    endfunction

    // One transaction; entered and left 1 time unit after a rising edge with
    // the DUT idle. gd = request cycle of the grant, rd = cycles from grant
    // to response (0 = same cycle). Response past the timeout window is never
    // delivered.
    task automatic txn(input logic st, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input int gd, input int rd,
                       input logic err, input logic [31:0] rdata, input logic probe_done);
        logic       legal;
        int         sz;
        int         resp_k;
        logic [3:0] we;
        string      outcome;
        legal  = is_legal(f3, st, a);
        sz     = acc_size(f3, st);
        resp_k = gd + rd;
        we     = st ? byte_en(a, sz) : 4'($urandom);
        req_valid = 1'b1; req_store = st; req_addr = a; req_funct3 = f3;
        req_wdata = wd; lsu_we = we;
        #1;
        chk("stall_accept", 32'(stall), 32'(legal));
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom);
        if (!legal) begin
            chk("misalign_pulse", 32'(misalign), 32'd1);
            chk("misalign_no_req", 32'(bus_req), 32'd0);
            chk("misalign_stall", 32'(stall), 32'd0);
            chk("misalign_lsu_f3", 32'(lsu_funct3), 32'(mdl_f3));
            @(posedge clk); #1;
            chk("misalign_clear", 32'(misalign), 32'd0);
            chk("misalign_idle_req", 32'(bus_req), 32'd0);
            $display("TXN %s addr=%h f3=%0d outcome=misalign", st ? "ST" : "LD", a, f3);
            return;
        end
        mdl_f3 = f3; mdl_lsb = a[1:0]; mdl_dir = ~st;
        chk("lsu_funct3", 32'(lsu_funct3), 32'(mdl_f3));
        chk("lsu_addr_lsb", 32'(lsu_addr_lsb), 32'(mdl_lsb));
        chk("lsu_dir", 32'(lsu_rd_or_wr_bar), 32'(mdl_dir));
        chk("bus_wr", 32'(bus_wr), 32'(st));
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        if (st) chk("bus_wdata", bus_wdata, replicate(wd, sz));
        for (int k = 0; k < TO; k++) begin
            bus_gnt    = (k == gd);
            bus_rvalid = (k == resp_k);
            bus_err    = err && (k == resp_k);
            bus_rdata  = (k == resp_k) ? rdata : $urandom;
            #1;
            chk("bus_req_phase", 32'(bus_req), 32'(k <= gd));
            chk("stall_busy", 32'(stall), 32'd1);
            if (k <= gd) begin
                chk("bus_wstrb", 32'(bus_wstrb), st ? 32'(we) : 32'd0);
                chk("bus_addr_stable", bus_addr, {a[31:2], 2'b00});
            end
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
            if (k == resp_k) break;
        end
        if (resp_k < TO && !err) begin
            outcome = "ok";
            if (!st) mdl_mem = rdata;
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("done_no_fault", 32'(bus_fault), 32'd0);
            chk("done_bus_req", 32'(bus_req), 32'd0);
            chk("lsu_mem_data", lsu_mem_data, mdl_mem);
            if (probe_done) begin
                req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
                #1;
                chk("done_stall_low", 32'(stall), 32'd0);
                @(posedge clk); #1;
                chk("done_not_sampled", 32'(bus_req), 32'd0);
                chk("done_pulse_once", 32'(resp_valid), 32'd0);
                req_valid = 1'b0;
            end else begin
                chk("done_stall", 32'(stall), 32'd0);
            end
        end else begin
            outcome = err && (resp_k < TO) ? "bus_err" : "timeout";
            chk("fault_pulse", 32'(bus_fault), 32'd1);
            chk("fault_no_resp", 32'(resp_valid), 32'd0);
            chk("fault_bus_req", 32'(bus_req), 32'd0);
            chk("fault_stall", 32'(stall), 32'd0);
            chk("fault_mem_kept", lsu_mem_data, mdl_mem);
        end
        @(posedge clk); #1;
        chk("after_resp", 32'(resp_valid), 32'd0);
        chk("after_fault", 32'(bus_fault), 32'd0);
        chk("after_stall", 32'(stall), 32'd0);
        $display("TXN %s addr=%h f3=%0d gnt=%0d rsp=%0d outcome=%s data=%h",
                 st ? "ST" : "LD", a, f3, gd, rd, outcome, lsu_mem_data);
    endtask

    // Start a word load, take it to REQ or WAIT, then assert reset mid-cycle.
    task automatic reset_mid(input logic in_wait);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_pre_req", 32'(bus_req), 32'd1);
        if (in_wait) begin
            bus_gnt = 1'b1;
            @(posedge clk); #1;
            bus_gnt = 1'b0;
            chk("rst_pre_wait", 32'(bus_req), 32'd0);
        end
        chk("rst_pre_stall", 32'(stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        mdl_mem = '0; mdl_f3 = '0; mdl_lsb = '0; mdl_dir = 1'b1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_fault", 32'(bus_fault), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_dir", 32'(lsu_rd_or_wr_bar), 32'd1);
        chk("rst_mem", lsu_mem_data, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_after_req", 32'(bus_req), 32'd0);
        chk("rst_after_resp", 32'(resp_valid), 32'd0);
        $display("TXN RESET in_%s", in_wait ? "WAIT" : "REQ");
    endtask

    initial begin
        logic       st;
        logic [2:0] f3;
        int         gd;
        int         rd;
        mdl_mem = '0; mdl_f3 = '0; mdl_lsb = '0; mdl_dir = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_bus_req", 32'(bus_req), 32'd0);
        chk("reset_resp", 32'(resp_valid), 32'd0);
        chk("reset_dir", 32'(lsu_rd_or_wr_bar), 32'd1);
        chk("reset_f3", 32'(lsu_funct3), 32'd0);
        chk("reset_mem", lsu_mem_data, 32'd0);
        chk("reset_wstrb", 32'(bus_wstrb), 32'd0);
        chk("reset_wr", 32'(bus_wr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // lw 0x100, granted at once, response next cycle
        txn(1'b0, 32'h100, 3'd2, 32'h0, 0, 1, 1'b0, 32'hDEADBEEF, 1'b0);
        // sb 0xA5 at 0x203
        txn(1'b1, 32'h203, 3'd0, 32'h123456A5, 1, 2, 1'b0, 32'h0, 1'b0);
        // sh at 0x202, lbu, lhu
        txn(1'b1, 32'h202, 3'd1, 32'hCAFEBABE, 0, 0, 1'b0, 32'h0, 1'b0);
        txn(1'b0, 32'h3, 3'd4, 32'h0, 2, 0, 1'b0, 32'h01020304, 1'b0);
        // misaligned lh and sw, illegal encodings
        txn(1'b0, 32'h101, 3'd1, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0);
        txn(1'b1, 32'h102, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0);
        txn(1'b1, 32'h100, 3'd4, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0);
        txn(1'b0, 32'h100, 3'd3, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0);
        // grant withheld: timeout
        txn(1'b0, 32'h300, 3'd2, 32'h0, 100, 0, 1'b0, 32'h0, 1'b0);
        // granted but no response: timeout in WAIT
        txn(1'b0, 32'h304, 3'd2, 32'h0, 1, 50, 1'b0, 32'h0, 1'b0);
        // response on the last allowed cycle
        txn(1'b0, 32'h308, 3'd2, 32'h0, 3, TO - 4, 1'b0, 32'h55AA33CC, 1'b0);
        // bus error response
        txn(1'b0, 32'h30C, 3'd2, 32'h0, 0, 2, 1'b1, 32'hFFFF0000, 1'b0);
        // request presented during DONE is not taken
        txn(1'b0, 32'h400, 3'd2, 32'h0, 0, 0, 1'b0, 32'h11223344, 1'b1);
        // reset mid-transaction, then normal traffic resumes
        reset_mid(1'b1);
        txn(1'b0, 32'h500, 3'd2, 32'h0, 0, 1, 1'b0, 32'h89ABCDEF, 1'b0);
        reset_mid(1'b0);
        txn(1'b1, 32'h504, 3'd2, 32'h76543210, 0, 1, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom);
            f3 = 3'($urandom);
            gd = $urandom_range(0, 5);
            rd = $urandom_range(0, 4);
            txn(st, $urandom, f3, $urandom, gd, rd, ($urandom_range(0, 5) == 0),
                $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Memory-access controller for the RV32I MEM stage. It latches a load/store request from the pipeline and presents the registered funct3, address low bits and direction flag to the load/store unit. It then runs a request/grant/response transaction on the data-memory bus and returns the raw word for the load/store unit to align. It stalls the pipeline for the whole transaction, replicates store data across byte lanes, and flags misaligned accesses and bus faults.

Parameters:
data_width, 32, data/address width
timeout_cycles, 64, max cycles from bus_req to bus_rvalid before fault (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  MEM stage holds a load or store
req_store  input  1  1=store, 0=load
req_addr  input  32  effective byte address
req_funct3  input  3  RV32I load/store funct3
req_wdata  input  32  rs2 value, unaligned
lsu_we  input  4  byte enables returned by load/store unit
lsu_funct3  output  3  registered funct3 to load/store unit
lsu_addr_lsb  output  2  registered req_addr[1:0]
lsu_rd_or_wr_bar  output  1  registered direction, 1=load, 0=store
lsu_mem_data  output  32  captured bus read word to load/store unit
stall  output  1  hold pipeline
resp_valid  output  1  one-cycle completion pulse
misalign  output  1  one-cycle misaligned/illegal-access pulse
bus_fault  output  1  one-cycle bus error/timeout pulse
bus_req  output  1  bus request
bus_wr  output  1  1=write transaction
bus_addr  output  32  word address, {addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_wstrb  output  4  byte strobes, 0000 for loads
bus_gnt  input  1  bus accepted request
bus_rvalid  input  1  response valid (read data or write ack)
bus_rdata  input  32  read data
bus_err  input  1  response is an error, qualified by bus_rvalid

Behaviour:
- Reset: clock is clk; reset rst_n is asynchronous, active-low. State=IDLE. All outputs and internal registers are 0, except lsu_rd_or_wr_bar=1. Reset asserted mid-transaction drops bus_req and stall immediately; no pulse is issued.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE with req_valid=1: legality is checked on req_funct3 and req_addr.
  - Illegal cases: funct3 in {011,110,111}; a store with funct3[2]=1; halfword with addr[0]=1; word with addr[1:0]!=00.
  - Illegal: misalign=1 next cycle, no bus activity, stay IDLE.
  - Legal: register funct3, addr, direction and wdata, then go to REQ.
- stall is combinational:
  - 1 in IDLE when req_valid=1 and the request is legal.
  - 1 in REQ and WAIT.
  - 0 in DONE and in IDLE otherwise.
- REQ:
  - bus_req=1. bus_addr, bus_wr, bus_wdata and bus_wstrb are driven from registers and stay stable until bus_gnt.
  - bus_wstrb=lsu_we for stores, 0000 for loads.
  - On bus_gnt go to WAIT; bus_req drops the following cycle.
- Store data replication:
  - sb: {4{wdata[7:0]}}
  - sh: {2{wdata[15:0]}}
  - sw: wdata
- WAIT:
  - On bus_rvalid with bus_err=0: for loads, lsu_mem_data<=bus_rdata; go to DONE.
  - On bus_rvalid with bus_err=1: bus_fault=1 next cycle, lsu_mem_data unchanged, go to IDLE, no resp_valid.
- DONE: resp_valid=1 for exactly one cycle, stall=0, go to IDLE. A new req_valid is not sampled in DONE; it is accepted on the following IDLE cycle.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - On reaching timeout_cycles without bus_rvalid: bus_fault pulse, go to IDLE, bus_req deasserted.
  - bus_gnt and bus_rvalid in the same cycle while in REQ: treated as grant then response, go directly to DONE.
- Latency (granted and responding immediately): req_valid accepted at cycle 0, bus_req at 1, DONE/resp_valid at 3.
- lsu_* outputs hold their last values until the next legal request is latched.

Test Plan:
- lw at 0x100, bus_gnt at cycle 1, bus_rvalid at cycle 2 with rdata 0xDEADBEEF -> bus_addr=0x100, bus_wstrb=0000, lsu_mem_data=0xDEADBEEF, resp_valid at cycle 3, stall 1 for cycles 0-2.
- sb 0xA5 at 0x203, lsu_we=1000 -> bus_addr=0x200, bus_wdata=0xA5A5A5A5, bus_wstrb=1000, bus_wr=1, resp_valid after write ack.
- lh at 0x101 and sw at 0x102 -> misalign pulse each, bus_req never asserted, stall 0.
- bus_gnt withheld, timeout_cycles=8 -> bus_fault pulse after 8 cycles, return to IDLE, bus_req 0, no resp_valid.
- lw with bus_rvalid and bus_err=1 -> bus_fault pulse, lsu_mem_data keeps its previous value, no resp_valid.
- rst_n low while in WAIT -> bus_req, stall and all pulses 0 immediately; after release, a new lw completes normally.
